// File: rtl/branch_pkg.sv
// Shared types and default widths for the branch unit and its return stack.
package branch_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned OFFSET_W_DEF = 9;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_REL  = 3'd1,
    BR_COND = 3'd2,
    JMP_ABS = 3'd3,
    CALL    = 3'd4,
    RET     = 3'd5
  } br_op_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } br_state_t;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module return_stack #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                     Clock,
  input  logic                     nReset,
  input  logic                     Push,
  input  logic                     Pop,
  input  logic [ADDR_W-1:0]        PushData,
  output logic [ADDR_W-1:0]        TopData,
  output logic [$clog2(DEPTH):0]   Depth,
  output logic                     Full,
  output logic                     Empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_sp;
  logic [PTR_W:0]    r_count;
  logic [PTR_W-1:0]  w_top_idx;

  assign w_top_idx = r_sp - PTR_W'(1);
  assign TopData   = r_mem[w_top_idx];
  assign Depth     = r_count;
  assign Full      = (r_count == (PTR_W+1)'(DEPTH));
  assign Empty     = (r_count == '0);

  // When full, r_sp has wrapped onto the oldest slot, so a push overwrites it.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (Push) begin
      r_sp <= r_sp + PTR_W'(1);
      if (!Full) r_count <= r_count + (PTR_W+1)'(1);
    end else if (Pop && !Empty) begin
      r_sp    <= w_top_idx;
      r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Push) r_mem[r_sp] <= PushData;
  end

endmodule

// File: rtl/branch_unit.sv
// Decode-side control-flow unit: registered PC redirect controls, return stack, shadow flush.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned OFFSET_W = OFFSET_W_DEF,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   InstrValid,
  input  br_op_t                 BrOp,
  input  logic [ADDR_W-1:0]      InstrPc,
  input  logic [ADDR_W-1:0]      Target,
  input  logic [OFFSET_W-1:0]    OffsetIn,
  input  logic                   CondTrue,
  output logic [ADDR_W-1:0]      LoadValue,
  output logic                   LoadEnable,
  output logic [OFFSET_W-1:0]    Offset,
  output logic                   OffsetEnable,
  output logic                   Flush,
  output logic [$clog2(DEPTH):0] Depth,
  output logic                   StackOverflow,
  output logic                   StackUnderflow
);

  br_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]   r_load_value, w_load_value;
  logic                r_load_en, w_load_en;
  logic [OFFSET_W-1:0] r_offset, w_offset;
  logic                r_off_en, w_off_en;
  logic                r_ovf, r_unf;
  logic                w_taken, w_push, w_pop, w_ovf_set, w_unf_set;
  logic [ADDR_W-1:0]   w_top;
  logic                w_full, w_empty;

  return_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_stack (
    .Clock    (Clock),
    .nReset   (nReset),
    .Push     (w_push),
    .Pop      (w_pop),
    .PushData (InstrPc + ADDR_W'(1)),
    .TopData  (w_top),
    .Depth    (Depth),
    .Full     (w_full),
    .Empty    (w_empty)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) r_state <= ST_RUN;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    if (r_state == ST_RUN && w_taken) w_state_nxt = ST_SHADOW;
  end

  // Decisions are only made in RUN; the shadow slot is dropped with no stack effect.
  always_comb begin
    w_taken      = 1'b0;
    w_load_en    = 1'b0;
    w_load_value = '0;
    w_off_en     = 1'b0;
    w_offset     = '0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    if (r_state == ST_RUN && InstrValid) begin
      case (BrOp)
        BR_REL: begin
          w_taken  = 1'b1;
          w_off_en = 1'b1;
          w_offset = OffsetIn;
        end
        BR_COND: begin
          if (CondTrue) begin
            w_taken  = 1'b1;
            w_off_en = 1'b1;
            w_offset = OffsetIn;
          end
        end
        JMP_ABS: begin
          w_taken      = 1'b1;
          w_load_en    = 1'b1;
          w_load_value = Target;
        end
        CALL: begin
          w_taken      = 1'b1;
          w_load_en    = 1'b1;
          w_load_value = Target;
          w_push       = 1'b1;
          w_ovf_set    = w_full;
        end
        RET: begin
          if (w_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_taken      = 1'b1;
            w_load_en    = 1'b1;
            w_load_value = w_top;
            w_pop        = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_load_value <= '0;
      r_load_en    <= 1'b0;
      r_offset     <= '0;
      r_off_en     <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
    end else begin
      r_load_value <= w_load_value;
      r_load_en    <= w_load_en;
      r_offset     <= w_offset;
      r_off_en     <= w_off_en;
      r_ovf        <= r_ovf | w_ovf_set;
      r_unf        <= r_unf | w_unf_set;
    end
  end

  assign LoadValue      = r_load_value;
  assign LoadEnable     = r_load_en;
  assign Offset         = r_offset;
  assign OffsetEnable   = r_off_en;
  assign Flush          = (r_state == ST_SHADOW);
  assign StackOverflow  = r_ovf;
  assign StackUnderflow = r_unf;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: queue-based stack model, directed and random stimulus.
module tb_branch_unit;
  import branch_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned OW = 9;
  localparam int unsigned DP = 8;
  localparam int unsigned DW = $clog2(DP) + 1;

  logic          Clock, nReset, InstrValid, CondTrue;
  br_op_t        BrOp;
  logic [AW-1:0] InstrPc, Target, LoadValue;
  logic [OW-1:0] OffsetIn, Offset;
  logic          LoadEnable, OffsetEnable, Flush, StackOverflow, StackUnderflow;
  logic [DW-1:0] Depth;

  branch_unit #(.ADDR_W(AW), .OFFSET_W(OW), .DEPTH(DP)) dut (
    .Clock(Clock), .nReset(nReset), .InstrValid(InstrValid), .BrOp(BrOp),
    .InstrPc(InstrPc), .Target(Target), .OffsetIn(OffsetIn), .CondTrue(CondTrue),
    .LoadValue(LoadValue), .LoadEnable(LoadEnable), .Offset(Offset),
    .OffsetEnable(OffsetEnable), .Flush(Flush), .Depth(Depth),
    .StackOverflow(StackOverflow), .StackUnderflow(StackUnderflow)
  );

  typedef struct {
    int unsigned   tag;
    logic [AW-1:0] lv;
    logic          le;
    logic [OW-1:0] off;
    logic          oe;
    logic          fl;
    logic [DW-1:0] dep;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] m_stk[$];
  bit            m_shadow, m_ovf, m_unf;
  int unsigned   errors = 0;
  int unsigned   checks = 0;
  int unsigned   cyc = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic model_reset();
    m_stk.delete();
    m_shadow = 0;
    m_ovf    = 0;
    m_unf    = 0;
    sb.delete();
  endtask

  task automatic clear_inputs();
    InstrValid = 0; BrOp = BR_NONE; InstrPc = '0; Target = '0; OffsetIn = '0; CondTrue = 0;
  endtask

  // Present one instruction for one cycle and record what the PC should see next cycle.
  task automatic issue(input bit v, input br_op_t op, input logic [AW-1:0] pc,
                       input logic [AW-1:0] tgt, input logic [OW-1:0] off, input bit c);
    exp_t e;
    bit   taken;
    @(posedge Clock); #1;
    InstrValid = v; BrOp = op; InstrPc = pc; Target = tgt; OffsetIn = off; CondTrue = c;
    e.tag = cyc + 1; e.lv = '0; e.le = 0; e.off = '0; e.oe = 0;
    taken = 0;
    if (!m_shadow && v) begin
      if (op == BR_REL || (op == BR_COND && c)) begin
        taken = 1; e.oe = 1; e.off = off;
      end else if (op == JMP_ABS) begin
        taken = 1; e.le = 1; e.lv = tgt;
      end else if (op == CALL) begin
        if (m_stk.size() == DP) begin
          void'(m_stk.pop_front());
          m_ovf = 1;
        end
        m_stk.push_back(pc + 16'd1);
        taken = 1; e.le = 1; e.lv = tgt;
      end else if (op == RET) begin
        if (m_stk.size() > 0) begin
          taken = 1; e.le = 1; e.lv = m_stk.pop_back();
        end else begin
          m_unf = 1;
        end
      end
    end
    m_shadow = taken;
    e.fl  = taken;
    e.dep = DW'(m_stk.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    sb.push_back(e);
  endtask

  task automatic idle();
    issue(0, BR_NONE, '0, '0, '0, 0);
  endtask

  task automatic chk_reset(input string name);
    checks++;
    if ({LoadValue, LoadEnable, Offset, OffsetEnable, Flush, Depth, StackOverflow, StackUnderflow} !== '0) begin
      errors++;
      $display("FAIL %s: got lv=%h le=%b off=%h oe=%b fl=%b dep=%0d ovf=%b unf=%b, expected all zero",
               name, LoadValue, LoadEnable, Offset, OffsetEnable, Flush, Depth, StackOverflow, StackUnderflow);
    end
  endtask

  always @(negedge Clock) begin : monitor
    exp_t e;
    if (nReset && sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.tag < cyc) begin
        errors++;
        $display("FAIL stale_entry: got check at cycle %0d, expected cycle %0d", cyc, e.tag);
      end else if ({LoadValue, LoadEnable, Offset, OffsetEnable, Flush, Depth, StackOverflow, StackUnderflow}
                   !== {e.lv, e.le, e.off, e.oe, e.fl, e.dep, e.ovf, e.unf}) begin
        errors++;
        $display("FAIL outputs@%0d: got lv=%h le=%b off=%h oe=%b fl=%b dep=%0d ovf=%b unf=%b, expected lv=%h le=%b off=%h oe=%b fl=%b dep=%0d ovf=%b unf=%b",
                 cyc, LoadValue, LoadEnable, Offset, OffsetEnable, Flush, Depth, StackOverflow, StackUnderflow,
                 e.lv, e.le, e.off, e.oe, e.fl, e.dep, e.ovf, e.unf);
      end
    end
  end

  initial begin
    nReset = 0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge Clock);
    #2 chk_reset("reset_state");
    @(negedge Clock) nReset = 1;

    // Relative branch, then not-taken conditional followed by an accepted jump.
    issue(1, BR_REL, 16'h0040, '0, 9'h1FB, 0);
    idle(); idle();
    issue(1, BR_COND, 16'h0050, '0, 9'h010, 0);
    issue(1, JMP_ABS, 16'h0051, 16'h1234, '0, 0);
    idle(); idle();
    issue(1, BR_COND, 16'h0060, '0, 9'h004, 1);
    idle();

    // Call / return pair.
    issue(1, CALL, 16'h0100, 16'h0800, '0, 0);
    idle(); idle();
    issue(1, RET, 16'h0800, '0, '0, 0);
    idle(); idle();

    // RET in the shadow slot must be ignored.
    issue(1, CALL, 16'h0200, 16'h0900, '0, 0);
    issue(1, RET, 16'h0900, '0, '0, 0);
    idle(); idle();
    issue(1, RET, 16'h0901, '0, '0, 0);
    idle();

    // Overflow and underflow.
    for (int i = 0; i < 9; i++) begin
      issue(1, CALL, AW'(i), 16'h4000, '0, 0);
      idle();
    end
    for (int i = 0; i < 9; i++) begin
      issue(1, RET, 16'h4000, '0, '0, 0);
      idle();
    end
    issue(1, CALL, 16'hFFFF, 16'h0010, '0, 0);
    idle();
    issue(1, RET, 16'h0010, '0, '0, 0);
    idle();

    for (int i = 0; i < 300; i++) begin
      issue(($urandom_range(0, 9) < 8), br_op_t'($urandom_range(0, 5)), AW'($urandom),
            AW'($urandom), OW'($urandom), 1'($urandom));
    end
    idle(); idle();

    // Asynchronous reset while a CALL redirect is being driven.
    issue(1, CALL, 16'h0300, 16'h0ABC, '0, 0);
    @(posedge Clock); #2;
    checks++;
    if (LoadEnable !== 1'b1 || LoadValue !== 16'h0ABC) begin
      errors++;
      $display("FAIL pre_reset_redirect: got le=%b lv=%h, expected le=1 lv=0abc", LoadEnable, LoadValue);
    end
    sb.delete();
    nReset = 0;
    clear_inputs();
    #1 chk_reset("async_reset_mid_redirect");
    @(negedge Clock);
    model_reset();
    nReset = 1;
    issue(1, RET, 16'h0400, '0, '0, 0);
    idle(); idle();

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge Clock);
    @(negedge Clock); #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
